// File: rtl/rr_mux4.sv
// Four-lane valid/ready round-robin merge into one tagged, registered stream.
// {s1,s0} carries the source lane so a 1-to-4 demux can route words back.
module rr_mux4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    output logic             rdy0,
    output logic             rdy1,
    output logic             rdy2,
    output logic             rdy3,
    output logic [WIDTH-1:0] out,
    output logic             s1,
    output logic             s0,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] lane [4];
    logic [3:0]       vld;
    logic [3:0]       rdy;
    logic [1:0]       last;
    logic [1:0]       gnt;
    logic [1:0]       cand;
    logic [1:0]       tag;
    logic             any;
    logic             load_en;

    assign lane[0] = in0;
    assign lane[1] = in1;
    assign lane[2] = in2;
    assign lane[3] = in3;
    assign vld     = {v3, v2, v1, v0};
    assign load_en = !out_valid || out_ready;

    // Offsets 1..4 from last; offset 4 wraps to last itself, checked last.
    always_comb begin
        any  = 1'b0;
        gnt  = last;
        cand = last;
        for (int unsigned i = 1; i < 5; i++) begin
            cand = last + 2'(i);
            if (!any && vld[cand]) begin
                any = 1'b1;
                gnt = cand;
            end
        end
    end

    assign rdy  = (load_en && any && !rst) ? (4'b0001 << gnt) : '0;
    assign rdy0 = rdy[0];
    assign rdy1 = rdy[1];
    assign rdy2 = rdy[2];
    assign rdy3 = rdy[3];
    assign {s1, s0} = tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            tag       <= '0;
            out_valid <= 1'b0;
            last      <= 2'd3;
        end else if (load_en) begin
            if (any) begin
                out       <= lane[gnt];
                tag       <= gnt;
                out_valid <= 1'b1;
                last      <= gnt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux4.sv
// Self-checking bench for rr_mux4: reference arbiter plus scoreboard queue,
// a vector table for round-robin/sparse/idle, and hand-written corner sequences.
module tb_rr_mux4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic [7:0] out;
    logic       s1, s0, out_valid;
    logic       out_ready = 1'b1;

    int total = 0;
    int bad   = 0;
    int m_last = 3;
    logic [9:0] sb [$];

    typedef struct {
        logic [3:0] v;
        logic       ordy;
        logic [7:0] d0, d1, d2, d3;
        logic [7:0] exp_out;
        logic [1:0] exp_tag;
        logic       exp_ov;
    } vec_t;

    vec_t tbl [10];

    rr_mux4 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3),
        .rdy0(rdy0), .rdy1(rdy1), .rdy2(rdy2), .rdy3(rdy3),
        .out(out), .s1(s1), .s0(s0),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_v(input logic [3:0] m);
        {v3, v2, v1, v0} = m;
    endtask

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic cycle();
        logic [3:0] vv;
        logic [3:0] exp_rdy;
        logic [7:0] dd [4];
        logic       any, load;
        int         g;
        #1;
        vv = {v3, v2, v1, v0};
        dd[0] = in0; dd[1] = in1; dd[2] = in2; dd[3] = in3;
        any = 1'b0;
        g = 0;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (!any && vv[idx]) begin
                any = 1'b1;
                g = idx;
            end
        end
        load = (sb.size() == 0) || out_ready;
        exp_rdy = (load && any) ? 4'(1 << g) : 4'b0000;
        chk("rdy", {28'd0, rdy3, rdy2, rdy1, rdy0}, {28'd0, exp_rdy});
        if (sb.size() > 0 && out_ready) void'(sb.pop_front());
        if (load && any) begin
            sb.push_back({dd[g], 2'(g)});
            m_last = g;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
        if (sb.size() > 0) begin
            chk("sb_out", {24'd0, out}, {24'd0, sb[0][9:2]});
            chk("sb_tag", {30'd0, s1, s0}, {30'd0, sb[0][1:0]});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        m_last = 3;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_tag", {30'd0, s1, s0}, 32'd0);
        chk("rst_rdy", {28'd0, rdy3, rdy2, rdy1, rdy0}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'hF, 1'b1, 8'h10, 8'h21, 8'h32, 8'h43, 8'h10, 2'd0, 1'b1};
        tbl[1] = '{4'hF, 1'b1, 8'h10, 8'h21, 8'h32, 8'h43, 8'h21, 2'd1, 1'b1};
        tbl[2] = '{4'hF, 1'b1, 8'h10, 8'h21, 8'h32, 8'h43, 8'h32, 2'd2, 1'b1};
        tbl[3] = '{4'hF, 1'b1, 8'h10, 8'h21, 8'h32, 8'h43, 8'h43, 2'd3, 1'b1};
        tbl[4] = '{4'hF, 1'b1, 8'h10, 8'h21, 8'h32, 8'h43, 8'h10, 2'd0, 1'b1};
        tbl[5] = '{4'hA, 1'b1, 8'h00, 8'h11, 8'h00, 8'h33, 8'h11, 2'd1, 1'b1};
        tbl[6] = '{4'hA, 1'b1, 8'h00, 8'h11, 8'h00, 8'h33, 8'h33, 2'd3, 1'b1};
        tbl[7] = '{4'hA, 1'b1, 8'h00, 8'h11, 8'h00, 8'h33, 8'h11, 2'd1, 1'b1};
        tbl[8] = '{4'hA, 1'b1, 8'h00, 8'h11, 8'h00, 8'h33, 8'h33, 2'd3, 1'b1};
        tbl[9] = '{4'h0, 1'b1, 8'h00, 8'h11, 8'h00, 8'h33, 8'h33, 2'd3, 1'b0};

        // Reset with all lanes valid, then first grant on first edge after release.
        set_v(4'hF);
        do_reset();
        set_v(4'h1);
        in0 = 8'hA0;
        cycle();
        chk("first_out", {24'd0, out}, 32'hA0);
        chk("first_tag", {30'd0, s1, s0}, 32'd0);
        chk("first_ov", {31'd0, out_valid}, 32'd1);

        do_reset();
        foreach (tbl[i]) begin
            set_v(tbl[i].v);
            out_ready = tbl[i].ordy;
            in0 = tbl[i].d0; in1 = tbl[i].d1; in2 = tbl[i].d2; in3 = tbl[i].d3;
            cycle();
            chk($sformatf("tbl%0d_out", i), {24'd0, out}, {24'd0, tbl[i].exp_out});
            chk($sformatf("tbl%0d_tag", i), {30'd0, s1, s0}, {30'd0, tbl[i].exp_tag});
            chk($sformatf("tbl%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
        end

        // Backpressure: hold 55 from lane 2 while lanes toggle, then no-bubble reload.
        set_v(4'h4);
        in2 = 8'h55;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            set_v((n % 2 == 0) ? 4'hF : 4'h0);
            cycle();
            chk("bp_out", {24'd0, out}, 32'h55);
            chk("bp_tag", {30'd0, s1, s0}, 32'd2);
            chk("bp_ov", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        set_v(4'h1);
        in0 = 8'h77;
        cycle();
        chk("bp_reload_out", {24'd0, out}, 32'h77);
        chk("bp_reload_tag", {30'd0, s1, s0}, 32'd0);
        chk("bp_reload_ov", {31'd0, out_valid}, 32'd1);

        // Async reset between edges while a word is held.
        out_ready = 1'b0;
        set_v(4'h0);
        @(posedge clk);
        #2;
        chk("pre_rst_ov", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_ov", {31'd0, out_valid}, 32'd0);
        chk("async_out", {24'd0, out}, 32'd0);
        chk("async_rdy", {28'd0, rdy3, rdy2, rdy1, rdy0}, 32'd0);
        sb.delete();
        m_last = 3;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        set_v(4'hF);
        in0 = 8'h10; in1 = 8'h21; in2 = 8'h32; in3 = 8'h43;
        cycle();
        chk("restart_out", {24'd0, out}, 32'h10);
        chk("restart_tag", {30'd0, s1, s0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        bad++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/rr_mux4.md
RR_MUX4 -- requirements
Module: rr_mux4

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every lane and of the output.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in0, in1, in2, in3  input  WIDTH each  lane data, lanes 0..3.
REQ-005 v0, v1, v2, v3  input  1 each  lane valid.
REQ-006 rdy0, rdy1, rdy2, rdy3  output  1 each  lane ready; lane N transfers when vN && rdyN at a clock edge.
REQ-007 out  output  WIDTH  registered merged data.
REQ-008 s1, s0  output  1 each  registered source-lane tag of out, {s1,s0} = lane index, matching the demux select encoding.
REQ-009 out_valid  output  1  out, s1 and s0 hold a valid word.
REQ-010 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready at a clock edge.

Function
REQ-011 The block SHALL merge four valid/ready lanes into one tagged stream, the inverse of the 1-to-4 demux; out/{s1,s0} route each word back to its lane.
REQ-012 Output stage: one-entry register (out, s1, s0, out_valid); load_en = !out_valid || out_ready.
REQ-013 Arbitration, combinational: when load_en = 1, grant the first lane with vN = 1, searching from (last+1) mod 4 upward with wrap; last = 2-bit index of the most recently granted lane.
REQ-014 rdyN = 1 only for the granted lane, only when load_en = 1; at most one rdyN high per cycle; rdyN does not depend on vN of any other lane except through arbitration.
REQ-015 On a lane transfer: out <= inN, {s1,s0} <= N, out_valid <= 1, last <= N.
REQ-016 If load_en = 1 and no lane valid: out_valid <= 0; out, s1, s0, last hold.
REQ-017 Latency: lane transfer at edge k -> out_valid = 1 with that word after edge k; one word per cycle sustained when out_ready = 1.
REQ-018 Backpressure: out_valid && !out_ready -> out, s1, s0, out_valid, last hold; all rdyN = 0.
REQ-019 Simultaneous drain and load in one cycle (out_valid && out_ready && granted lane valid) -> new word replaces old, out_valid stays 1, no bubble.
REQ-020 Fairness: with all four lanes continuously valid and out_ready = 1, grant order is strictly 0,1,2,3,0,...; no lane waits more than 3 grants.
REQ-021 Wrap-around: last = 3 -> search starts at lane 0.
REQ-022 Input vN may deassert without a transfer; the block does not require valid to be held.

Reset
REQ-023 While rst = 1, and immediately on its assertion: out = 0, s1 = 0, s0 = 0, out_valid = 0, last = 3 (first search starts at lane 0).
REQ-024 All rdyN are 0 while rst = 1.
REQ-025 Reset mid-transfer discards the held word; no partial or duplicate word appears after rst deasserts.
REQ-026 First grant possible on the first rising edge with rst = 0.

Verification
REQ-027 Reset: rst = 1 with v0..v3 = 1 -> out_valid = 0, {s1,s0} = 00, all rdyN = 0; release rst, in0 = 8'hA0 -> after the first edge, out = A0, {s1,s0} = 00, out_valid = 1.
REQ-028 Round-robin: in0..in3 = 8'h10, 8'h21, 8'h32, 8'h43, all valid, out_ready = 1 -> output sequence 10/00, 21/01, 32/10, 43/11, 10/00 on consecutive cycles.
REQ-029 Backpressure: word 8'h55 from lane 2 held, out_ready = 0 for 5 cycles -> out = 55, {s1,s0} = 10 stable, all rdyN = 0; then out_ready = 1 -> next word loads the same cycle, no bubble.
REQ-030 Sparse lanes: only v1 and v3 valid (in1 = 8'h11, in3 = 8'h33) -> alternating 11/01, 33/11; idle lanes never granted.
REQ-031 Idle: no lane valid, out_ready = 1 -> out_valid falls to 0 after one edge; out holds the last value.
REQ-032 Async reset mid-stream: assert rst between edges while out_valid = 1 -> out_valid = 0 before the next edge; after release, the grant restarts at lane 0.
